// File: rtl/latency_pipe_pkg.sv
// Shared helpers for the latency pipe: width math and channel slicing.
package latency_pipe_pkg;

    // Ceiling log2; clog2_f(1) == 0, clog2_f(17) == 5.
    function automatic int unsigned clog2_f(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width needed to hold any delay in 0..max_latency.
    function automatic int unsigned dly_width(input int unsigned max_latency);
        return clog2_f(max_latency + 1);
    endfunction

    // LSB position of channel ch inside a packed multi-channel word.
    function automatic int unsigned ch_lo(input int unsigned ch, input int unsigned data_width);
        return ch * data_width;
    endfunction

endpackage

// File: rtl/latency_pipe_if.sv
// Stream and configuration signals of one latency_pipe channel group.
interface latency_pipe_if #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned NUM_CH      = 1,
    parameter int unsigned MAX_LATENCY = 16
);
    import latency_pipe_pkg::*;

    localparam int unsigned DLY_W = dly_width(MAX_LATENCY);

    logic                         en;
    logic                         flush;
    logic                         cfg_load;
    logic [DLY_W-1:0]             cfg_delay;
    logic [NUM_CH*DATA_WIDTH-1:0] din;
    logic                         din_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] dout;
    logic                         dout_valid;
    logic [DLY_W-1:0]             cur_delay;
    logic                         primed;
    logic                         cfg_clamped;

    modport master (
        output en, flush, cfg_load, cfg_delay, din, din_valid,
        input  dout, dout_valid, cur_delay, primed, cfg_clamped
    );

    modport slave (
        input  en, flush, cfg_load, cfg_delay, din, din_valid,
        output dout, dout_valid, cur_delay, primed, cfg_clamped
    );

endinterface

// File: rtl/latency_tap_mux.sv
// Selects the output tap {vld, stage} for the active delay, with a zero-delay bypass.
module latency_tap_mux #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MAX_LATENCY = 16,
    parameter int unsigned DLY_W       = 5
) (
    input  logic [DLY_W-1:0]                  cur_delay_i,
    input  logic [MAX_LATENCY-1:0][WIDTH-1:0] stage_i,
    input  logic [MAX_LATENCY-1:0]            vld_i,
    input  logic [WIDTH-1:0]                  din_i,
    input  logic                              din_valid_i,
    input  logic                              bypass_ok_i,
    output logic [WIDTH-1:0]                  dout_o,
    output logic                              dout_valid_o
);

    // Delay d>=1 taps stage d-1; d=0 passes the input straight through.
    always_comb begin
        dout_o       = '0;
        dout_valid_o = 1'b0;
        if (cur_delay_i == '0) begin
            dout_o       = din_i;
            dout_valid_o = din_valid_i & bypass_ok_i;
        end else begin
            for (int k = 1; k <= MAX_LATENCY; k++) begin
                if (cur_delay_i == DLY_W'(k)) begin
                    dout_o       = stage_i[k-1];
                    dout_valid_o = vld_i[k-1];
                end
            end
        end
    end

endmodule

// File: rtl/latency_pipe.sv
// Valid-tagged delay line with run-time latency, stall, flush and fill tracking.
module latency_pipe #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned NUM_CH          = 1,
    parameter int unsigned MAX_LATENCY     = 16,
    parameter int unsigned DEFAULT_LATENCY = 4
) (
    input logic           clk,
    input logic           rst_n,
    latency_pipe_if.slave bus
);
    import latency_pipe_pkg::*;

    localparam int unsigned W     = DATA_WIDTH * NUM_CH;
    localparam int unsigned DLY_W = dly_width(MAX_LATENCY);

    localparam logic [DLY_W-1:0] MaxDly = DLY_W'(MAX_LATENCY);
    localparam logic [DLY_W-1:0] DefDly = DLY_W'(DEFAULT_LATENCY);

    logic [MAX_LATENCY-1:0][W-1:0] stage_q, stage_d;
    logic [MAX_LATENCY-1:0]        vld_q, vld_d;
    logic [DLY_W-1:0]              cur_delay_q, cur_delay_d;
    logic [DLY_W-1:0]              fill_cnt_q, fill_cnt_d;
    logic                          cfg_clamped_q, cfg_clamped_d;

    logic flush_any;
    logic shift;

    // A config load always restarts the pipe, so it counts as a flush.
    assign flush_any = bus.flush | bus.cfg_load;
    assign shift     = bus.en & ~flush_any;

    // Next-state: flush beats shift; en=0 holds everything.
    always_comb begin
        stage_d       = stage_q;
        vld_d         = vld_q;
        cur_delay_d   = cur_delay_q;
        fill_cnt_d    = fill_cnt_q;
        cfg_clamped_d = 1'b0;

        if (flush_any) begin
            // Data stages keep stale values; only the tags need clearing.
            vld_d      = '0;
            fill_cnt_d = '0;
        end else if (bus.en) begin
            stage_d[0] = bus.din;
            vld_d[0]   = bus.din_valid;
            for (int k = 1; k < MAX_LATENCY; k++) begin
                stage_d[k] = stage_q[k-1];
                vld_d[k]   = vld_q[k-1];
            end
            if (fill_cnt_q < cur_delay_q) begin
                fill_cnt_d = fill_cnt_q + 1'b1;
            end
        end

        if (bus.cfg_load) begin
            if (bus.cfg_delay > MaxDly) begin
                cur_delay_d   = MaxDly;
                cfg_clamped_d = 1'b1;
            end else begin
                cur_delay_d = bus.cfg_delay;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q       <= '0;
            vld_q         <= '0;
            cur_delay_q   <= DefDly;
            fill_cnt_q    <= '0;
            cfg_clamped_q <= 1'b0;
        end else begin
            stage_q       <= stage_d;
            vld_q         <= vld_d;
            cur_delay_q   <= cur_delay_d;
            fill_cnt_q    <= fill_cnt_d;
            cfg_clamped_q <= cfg_clamped_d;
        end
    end

    latency_tap_mux #(
        .WIDTH       (W),
        .MAX_LATENCY (MAX_LATENCY),
        .DLY_W       (DLY_W)
    ) u_tap_mux (
        .cur_delay_i  (cur_delay_q),
        .stage_i      (stage_q),
        .vld_i        (vld_q),
        .din_i        (bus.din),
        .din_valid_i  (bus.din_valid),
        .bypass_ok_i  (shift),
        .dout_o       (bus.dout),
        .dout_valid_o (bus.dout_valid)
    );

    assign bus.cur_delay   = cur_delay_q;
    assign bus.primed      = (fill_cnt_q == cur_delay_q);
    assign bus.cfg_clamped = cfg_clamped_q;

endmodule

// File: tb/tb_latency_pipe.sv
// Directed bench for latency_pipe: NUM_CH=3, DATA_WIDTH=8, MAX_LATENCY=16, DEFAULT_LATENCY=4.
module tb_latency_pipe;
    import latency_pipe_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned NC = 3;
    localparam int unsigned ML = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    latency_pipe_if #(.DATA_WIDTH(DW), .NUM_CH(NC), .MAX_LATENCY(ML)) bus ();

    latency_pipe #(
        .DATA_WIDTH      (DW),
        .NUM_CH          (NC),
        .MAX_LATENCY     (ML),
        .DEFAULT_LATENCY (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [23:0] din;
        logic        dv;
        logic [23:0] exp_dout;
        logic        exp_dv;
        logic        exp_primed;
        logic [4:0]  exp_cur;
    } vec_t;

    vec_t vecs[$];

    // Distinct value per channel: ch0=c, ch1=c+16, ch2=c+32.
    function automatic logic [23:0] mk(input int c);
        return {8'(c + 32), 8'(c + 16), 8'(c)};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addv(input logic en, input logic [23:0] din, input logic dv,
                        input logic [23:0] ed, input logic ev, input logic ep);
        vec_t v;
        v.en = en; v.din = din; v.dv = dv;
        v.exp_dout = ed; v.exp_dv = ev; v.exp_primed = ep; v.exp_cur = 5'd4;
        vecs.push_back(v);
    endtask

    initial begin
        logic [23:0] a5;
        logic [23:0] ff;
        logic        ev;
        checks = 0;
        errors = 0;
        a5 = {3{8'hA5}};
        ff = {3{8'hFF}};

        bus.en = 1'b0; bus.flush = 1'b0; bus.cfg_load = 1'b0; bus.cfg_delay = '0;
        bus.din = '0; bus.din_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst dout", 32'(bus.dout), 32'h0);
        chk("rst dout_valid", 32'(bus.dout_valid), 32'h0);
        chk("rst cur_delay", 32'(bus.cur_delay), 32'd4);
        chk("rst primed", 32'(bus.primed), 32'h0);
        chk("rst cfg_clamped", 32'(bus.cfg_clamped), 32'h0);

        // Fill with constant 0xA5, then a counting pattern with en toggling.
        addv(1, a5, 1, 24'h0, 0, 0);
        addv(1, a5, 1, 24'h0, 0, 0);
        addv(1, a5, 1, 24'h0, 0, 0);
        addv(1, a5, 1, a5, 1, 1);
        addv(1, a5, 1, a5, 1, 1);
        addv(1, mk(1), 1, a5, 1, 1);
        addv(0, ff, 1, a5, 1, 1);
        addv(1, mk(2), 1, a5, 1, 1);
        addv(0, ff, 1, a5, 1, 1);
        addv(1, mk(3), 1, a5, 1, 1);
        addv(0, ff, 1, a5, 1, 1);
        addv(1, mk(4), 1, mk(1), 1, 1);
        addv(0, ff, 1, mk(1), 1, 1);
        addv(1, mk(5), 1, mk(2), 1, 1);
        addv(0, ff, 1, mk(2), 1, 1);
        addv(1, mk(6), 1, mk(3), 1, 1);

        foreach (vecs[i]) begin
            bus.en = vecs[i].en;
            bus.din = vecs[i].din;
            bus.din_valid = vecs[i].dv;
            tick();
            chk($sformatf("vec%0d dout", i), 32'(bus.dout), 32'(vecs[i].exp_dout));
            chk($sformatf("vec%0d dout_valid", i), 32'(bus.dout_valid), 32'(vecs[i].exp_dv));
            chk($sformatf("vec%0d primed", i), 32'(bus.primed), 32'(vecs[i].exp_primed));
            chk($sformatf("vec%0d cur_delay", i), 32'(bus.cur_delay), 32'(vecs[i].exp_cur));
        end

        // Reload to 9 mid-stream: nothing valid for 9 enabled cycles.
        bus.en = 1'b1; bus.cfg_load = 1'b1; bus.cfg_delay = 5'd9;
        bus.din = mk(7); bus.din_valid = 1'b1;
        tick();
        chk("cfg9 cur_delay", 32'(bus.cur_delay), 32'd9);
        chk("cfg9 dout_valid", 32'(bus.dout_valid), 32'h0);
        chk("cfg9 primed", 32'(bus.primed), 32'h0);
        chk("cfg9 cfg_clamped", 32'(bus.cfg_clamped), 32'h0);
        bus.cfg_load = 1'b0;
        for (int j = 0; j < 10; j++) begin
            bus.din = mk(10 + j);
            tick();
            ev = (j >= 8);
            chk($sformatf("cfg9 step%0d dout_valid", j), 32'(bus.dout_valid), 32'(ev));
            chk($sformatf("cfg9 step%0d primed", j), 32'(bus.primed), 32'(ev));
            if (j >= 8) chk($sformatf("cfg9 step%0d dout", j), 32'(bus.dout), 32'(mk(2 + j)));
        end

        // Oversized request clamps to 16 with a one-cycle flag.
        bus.cfg_load = 1'b1; bus.cfg_delay = 5'd31; bus.din = mk(30);
        tick();
        chk("clamp cur_delay", 32'(bus.cur_delay), 32'd16);
        chk("clamp cfg_clamped", 32'(bus.cfg_clamped), 32'h1);
        chk("clamp dout_valid", 32'(bus.dout_valid), 32'h0);
        bus.cfg_load = 1'b0;
        for (int j = 0; j < 17; j++) begin
            bus.din = mk(40 + j);
            tick();
            if (j == 0) chk("clamp pulse end", 32'(bus.cfg_clamped), 32'h0);
            ev = (j >= 15);
            chk($sformatf("clamp step%0d dout_valid", j), 32'(bus.dout_valid), 32'(ev));
            if (j >= 15) chk($sformatf("clamp step%0d dout", j), 32'(bus.dout), 32'(mk(25 + j)));
        end

        // Zero delay: combinational bypass, gated by flush and en.
        bus.cfg_load = 1'b1; bus.cfg_delay = 5'd0; bus.din = mk(50);
        tick();
        bus.cfg_load = 1'b0; bus.din = mk(51);
        #1;
        chk("d0 cur_delay", 32'(bus.cur_delay), 32'd0);
        chk("d0 dout", 32'(bus.dout), 32'(mk(51)));
        chk("d0 dout_valid", 32'(bus.dout_valid), 32'h1);
        chk("d0 primed", 32'(bus.primed), 32'h1);
        bus.flush = 1'b1;
        #1;
        chk("d0 flush dout_valid", 32'(bus.dout_valid), 32'h0);
        tick();
        bus.flush = 1'b0; bus.en = 1'b0;
        #1;
        chk("d0 stall dout_valid", 32'(bus.dout_valid), 32'h0);
        chk("d0 stall dout", 32'(bus.dout), 32'(mk(51)));
        bus.en = 1'b1;
        #1;
        chk("d0 resume dout_valid", 32'(bus.dout_valid), 32'h1);

        // Delay 4, flush a valid sample: it must never appear.
        bus.cfg_load = 1'b1; bus.cfg_delay = 5'd4; bus.din = mk(59);
        tick();
        bus.cfg_load = 1'b0; bus.din = mk(60);
        tick();
        bus.flush = 1'b1; bus.din = mk(61);
        tick();
        bus.flush = 1'b0;
        for (int j = 0; j < 5; j++) begin
            bus.din = mk(62 + j);
            tick();
            ev = (j >= 3);
            chk($sformatf("flush step%0d dout_valid", j), 32'(bus.dout_valid), 32'(ev));
            chk($sformatf("flush step%0d primed", j), 32'(bus.primed), 32'(ev));
            if (j >= 3) begin
                chk($sformatf("flush step%0d dout", j), 32'(bus.dout), 32'(mk(59 + j)));
                for (int ch = 0; ch < 3; ch++) begin
                    chk($sformatf("flush step%0d ch%0d", j, ch),
                        32'(bus.dout[ch_lo(ch, DW) +: 8]), 32'(8'(59 + j + 16 * ch)));
                end
            end
        end

        // Asynchronous reset mid-stream clears outputs immediately.
        rst_n = 1'b0;
        #1;
        chk("arst dout", 32'(bus.dout), 32'h0);
        chk("arst dout_valid", 32'(bus.dout_valid), 32'h0);
        chk("arst primed", 32'(bus.primed), 32'h0);
        chk("arst cur_delay", 32'(bus.cur_delay), 32'd4);
        #2;
        rst_n = 1'b1;
        bus.din = mk(70);
        tick();
        chk("arst first dout_valid", 32'(bus.dout_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
